// File: rtl/i2c_pkg.sv
`default_nettype none
//==============================================================================
// Package : i2c_pkg
// Brief   : Shared types for the I2C master arbiter: the latched request record,
//           the arbiter state encoding and width helpers.
// Revision: 1.0 - initial release
//==============================================================================
package i2c_pkg;

  // Width of a requester index (covers up to 8 requesters)
  localparam int GRANT_W = 3;

  typedef struct packed {
    logic [6:0] daddr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wen;
  } i2c_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Width of a counter able to hold values 0..limit (never narrower than 1)
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_arbiter_rr_pick.sv
`default_nettype none
//==============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin selector. Scans last+1, last+2, ...
//           (mod N_REQ) and returns the first requesting index.
// Revision: 1.0 - initial release
//==============================================================================
module rr_pick
  import i2c_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [GRANT_W-1:0] grant_o,
  output logic               any_o
);

  localparam int IDX_W = GRANT_W + 1;

  logic [IDX_W-1:0] idx;
  logic             hit;

  // Walk candidates farthest-first so the nearest requester after last wins
  always_comb begin
    grant_o = '0;
    any_o   = |req_i;
    idx     = '0;
    hit     = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = {1'b0, last_i} + IDX_W'(k);
      if (idx >= IDX_W'(N_REQ)) idx = idx - IDX_W'(N_REQ);
      hit = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
        if (idx == IDX_W'(j)) hit = req_i[j];
      end
      if (hit) grant_o = idx[GRANT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : i2c_arbiter
// Brief   : Round-robin sharing of one byte-register I2C master among N_REQ
//           requesters, one transaction in flight, with response timeout.
// Revision: 1.0 - initial release
//==============================================================================
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int         N_REQ    = 4,
  parameter int         TIMEOUT  = 65536,
  parameter logic [7:0] ERR_DATA = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  srst_i,
  input  logic [N_REQ-1:0]      req_val_i,
  input  logic [N_REQ-1:0][6:0] req_daddr_i,
  input  logic [N_REQ-1:0][7:0] req_addr_i,
  input  logic [N_REQ-1:0][7:0] req_data_i,
  input  logic [N_REQ-1:0]      req_wen_i,
  output logic [N_REQ-1:0]      req_rdy_o,
  output logic [N_REQ-1:0]      rsp_val_o,
  output logic                  rsp_err_o,
  output logic [7:0]            rsp_data_o,
  input  logic [N_REQ-1:0]      rsp_rdy_i,
  output logic                  m_val_o,
  output logic [6:0]            m_daddr_o,
  output logic [7:0]            m_addr_o,
  output logic [7:0]            m_data_o,
  output logic                  m_wen_o,
  input  logic                  m_rdy_i,
  input  logic                  m_val_i,
  input  logic                  m_err_i,
  input  logic [7:0]            m_data_i,
  output logic                  m_rdy_o,
  output logic [2:0]            grant_o,
  output logic                  busy_o,
  output logic                  stray_o
);

  arb_state_e         state_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] last_q;
  i2c_req_t           req_q;
  logic [7:0]         rsp_data_q;
  logic               rsp_err_q;
  logic               m_rdy_q;
  logic               stray_q;

  logic [GRANT_W-1:0] w_pick;
  logic               w_any;
  logic               w_accept;
  i2c_req_t           w_sel;
  logic [N_REQ-1:0]   w_pick_hot;
  logic [N_REQ-1:0]   w_grant_hot;
  logic               w_rsp_rdy;
  logic               w_timeout;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i   (req_val_i),
    .last_i  (last_q),
    .grant_o (w_pick),
    .any_o   (w_any)
  );

  // Mux the picked requester's fields and decode one-hot views of pick/grant
  always_comb begin
    w_sel       = '0;
    w_pick_hot  = '0;
    w_grant_hot = '0;
    w_rsp_rdy   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == GRANT_W'(i)) begin
        w_sel.daddr   = req_daddr_i[i];
        w_sel.addr    = req_addr_i[i];
        w_sel.data    = req_data_i[i];
        w_sel.wen     = req_wen_i[i];
        w_pick_hot[i] = 1'b1;
      end
      if (grant_q == GRANT_W'(i)) begin
        w_grant_hot[i] = 1'b1;
        w_rsp_rdy      = rsp_rdy_i[i];
      end
    end
  end

  // Accept is only offered from IDLE and never while either reset is active
  assign w_accept  = (state_q == IDLE) && w_any && !rst_i && !srst_i;
  assign req_rdy_o = w_accept ? w_pick_hot : '0;

  if (TIMEOUT != 0) begin : g_timeout
    localparam int CNT_W = cnt_width(TIMEOUT);
    logic [CNT_W-1:0] cnt_q;

    // Cycles spent in WAIT since the master took the transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                 cnt_q <= '0;
      else if (srst_i)           cnt_q <= '0;
      else if (state_q == ISSUE) cnt_q <= '0;
      else if (state_q == WAIT)  cnt_q <= cnt_q + CNT_W'(1);
    end

    assign w_timeout = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  // Arbiter FSM with its registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GRANT_W'(N_REQ - 1);
      req_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      m_rdy_q    <= 1'b0;
      stray_q    <= 1'b0;
    end else if (srst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GRANT_W'(N_REQ - 1);
      req_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      m_rdy_q    <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      stray_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          m_rdy_q <= 1'b1;
          if (m_val_i && m_rdy_q) stray_q <= 1'b1;
          if (w_any) begin
            grant_q <= w_pick;
            req_q   <= w_sel;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_val_i && m_rdy_q) stray_q <= 1'b1;
          if (m_rdy_i) state_q <= WAIT;
        end
        WAIT: begin
          // A real response in the timeout cycle wins over the timeout
          if (m_val_i) begin
            rsp_data_q <= m_data_i;
            rsp_err_q  <= m_err_i;
            m_rdy_q    <= 1'b0;
            state_q    <= RESP;
          end else if (w_timeout) begin
            rsp_data_q <= ERR_DATA;
            rsp_err_q  <= 1'b1;
            m_rdy_q    <= 1'b0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (w_rsp_rdy) begin
            last_q  <= grant_q;
            m_rdy_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_val_o    = (state_q == ISSUE);
  assign m_daddr_o  = req_q.daddr;
  assign m_addr_o   = req_q.addr;
  assign m_data_o   = req_q.data;
  assign m_wen_o    = req_q.wen;
  assign m_rdy_o    = m_rdy_q;
  assign rsp_val_o  = (state_q == RESP) ? w_grant_hot : '0;
  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);
  assign stray_o    = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_i2c_arbiter
// Brief   : Self-checking bench for i2c_arbiter (N_REQ=4, TIMEOUT=16) against
//           a round-robin reference model and a scripted master.
// Revision: 1.0 - initial release
//==============================================================================
module tb_i2c_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            srst = 1'b0;
  logic [N-1:0]    req_val = '0;
  logic [N-1:0][6:0] req_daddr = '0;
  logic [N-1:0][7:0] req_addr = '0;
  logic [N-1:0][7:0] req_data = '0;
  logic [N-1:0]    req_wen = '0;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    rsp_val;
  logic            rsp_err;
  logic [7:0]      rsp_data;
  logic [N-1:0]    rsp_rdy = '0;
  logic            m_val_o;
  logic [6:0]      m_daddr;
  logic [7:0]      m_addr;
  logic [7:0]      m_wdata;
  logic            m_wen;
  logic            m_rdy_i = 1'b1;
  logic            m_val_i = 1'b0;
  logic            m_err_i = 1'b0;
  logic [7:0]      m_data_i = '0;
  logic            m_rdy_o;
  logic [2:0]      grant;
  logic            busy;
  logic            stray;

  int errors = 0;
  int checks = 0;
  int last_m = N - 1;

  i2c_arbiter #(.N_REQ(N), .TIMEOUT(16), .ERR_DATA(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst), .srst_i(srst),
    .req_val_i(req_val), .req_daddr_i(req_daddr), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_wen_i(req_wen), .req_rdy_o(req_rdy),
    .rsp_val_o(rsp_val), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
    .rsp_rdy_i(rsp_rdy),
    .m_val_o(m_val_o), .m_daddr_o(m_daddr), .m_addr_o(m_addr),
    .m_data_o(m_wdata), .m_wen_o(m_wen), .m_rdy_i(m_rdy_i),
    .m_val_i(m_val_i), .m_err_i(m_err_i), .m_data_i(m_data_i),
    .m_rdy_o(m_rdy_o), .grant_o(grant), .busy_o(busy), .stray_o(stray)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round robin: first requester after 'last' going upward, wrapping
  function automatic int rr_exp(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_fields(input int i);
    req_daddr[i] = 7'($urandom);
    req_addr[i]  = 8'($urandom);
    req_data[i]  = 8'($urandom);
    req_wen[i]   = 1'($urandom);
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (m_val_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Master side of one transaction: take it, answer after dly WAIT cycles, ack response
  task automatic serve(input int dly, input logic [7:0] d, input logic e,
                       output bit ok, output logic [2:0] g, output logic [6:0] da,
                       output logic [7:0] ad, output logic [7:0] dt, output logic w,
                       output logic [N-1:0] rv, output logic [7:0] rd, output logic re);
    g = '0; da = '0; ad = '0; dt = '0; w = 1'b0; rv = '0; rd = '0; re = 1'b0;
    wait_issue(ok);
    if (!ok) return;
    g = grant; da = m_daddr; ad = m_addr; dt = m_wdata; w = m_wen;
    tick();
    repeat (dly) tick();
    m_val_i = 1'b1; m_data_i = d; m_err_i = e;
    tick();
    m_val_i = 1'b0; m_err_i = 1'b0;
    rv = rsp_val; rd = rsp_data; re = rsp_err;
    rsp_rdy = '1;
    tick();
    rsp_rdy = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_val_o !== 1'b0) begin errors++; $display("FAIL reset_m_val: got %b want 0", m_val_o); end
    checks++; if (m_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_m_rdy: got %b want 0", m_rdy_o); end
    checks++; if (rsp_val !== 4'b0) begin errors++; $display("FAIL reset_rsp_val: got %b want 0000", rsp_val); end
    checks++; if ({busy, stray, grant} !== 5'b0) begin errors++; $display("FAIL reset_status: got %b want 00000", {busy, stray, grant}); end
    checks++; if ({rsp_data, rsp_err} !== 9'b0) begin errors++; $display("FAIL reset_rsp_data: got %h want 000", {rsp_data, rsp_err}); end
    rst = 1'b0;
    tick();
    checks++; if (m_rdy_o !== 1'b1) begin errors++; $display("FAIL idle_m_rdy: got %b want 1", m_rdy_o); end
    last_m = N - 1;
  endtask

  task automatic test_round_robin();
    bit ok; logic [2:0] g; logic [6:0] da; logic [7:0] ad, dt, rd; logic w, re; logic [N-1:0] rv;
    int exp; logic [7:0] d;
    for (int i = 0; i < N; i++) rand_fields(i);
    req_val = '1;
    for (int t = 0; t < 8; t++) begin
      exp = rr_exp(req_val, last_m);
      d = 8'($urandom);
      serve($urandom_range(0, 8), d, 1'b0, ok, g, da, ad, dt, w, rv, rd, re);
      checks++; if (!ok) begin errors++; $display("FAIL rr_issue_timeout: txn %0d never issued", t); end
      checks++; if (g !== 3'(t % N)) begin errors++; $display("FAIL rr_order: txn %0d got %0d want %0d", t, g, t % N); end
      checks++; if ({da, ad, dt, w} !== {req_daddr[exp], req_addr[exp], req_data[exp], req_wen[exp]})
        begin errors++; $display("FAIL rr_fields: got %h want %h", {da, ad, dt, w}, {req_daddr[exp], req_addr[exp], req_data[exp], req_wen[exp]}); end
      checks++; if ({rv, rd, re} !== {4'(1 << exp), d, 1'b0})
        begin errors++; $display("FAIL rr_rsp: got %h want %h", {rv, rd, re}, {4'(1 << exp), d, 1'b0}); end
      last_m = exp;
    end
    req_val = '0;
  endtask

  task automatic test_single_read();
    bit ok;
    req_daddr[0] = 7'h20; req_addr[0] = 8'h13; req_wen[0] = 1'b0;
    req_val = 4'b0001;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL single_accept: got %b want 0001", req_rdy); end
    wait_issue(ok);
    req_val = '0;
    checks++; if (!ok) begin errors++; $display("FAIL single_issue: no m_val_o"); end
    checks++; if ({m_daddr, m_addr, m_wen} !== {7'h20, 8'h13, 1'b0})
      begin errors++; $display("FAIL single_m_fields: got %h want %h", {m_daddr, m_addr, m_wen}, {7'h20, 8'h13, 1'b0}); end
    tick();
    repeat (9) tick();
    m_val_i = 1'b1; m_data_i = 8'hA5;
    tick();
    m_val_i = 1'b0;
    checks++; if ({rsp_val, rsp_data, rsp_err} !== {4'b0001, 8'hA5, 1'b0})
      begin errors++; $display("FAIL single_rsp: got %h want %h", {rsp_val, rsp_data, rsp_err}, {4'b0001, 8'hA5, 1'b0}); end
    rsp_rdy = 4'b0001;
    tick();
    rsp_rdy = '0;
    checks++; if ({rsp_val, busy} !== 5'b0) begin errors++; $display("FAIL single_done: got %b want 00000", {rsp_val, busy}); end
    last_m = 0;
  endtask

  task automatic test_late_request();
    bit ok; logic [2:0] g; logic [6:0] da; logic [7:0] ad, dt, rd; logic w, re; logic [N-1:0] rv;
    req_val = 4'b0100;
    wait_issue(ok);
    checks++; if (!ok || grant !== 3'd2) begin errors++; $display("FAIL late_first_grant: got %0d want 2", grant); end
    req_val = 4'b0001;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_rdy !== 4'b0) begin errors++; $display("FAIL late_no_accept: got %b want 0000", req_rdy); end
      tick();
    end
    m_val_i = 1'b1; m_data_i = 8'h5A;
    tick();
    m_val_i = 1'b0;
    checks++; if (rsp_val !== 4'b0100) begin errors++; $display("FAIL late_rsp2: got %b want 0100", rsp_val); end
    rsp_rdy = 4'b0100;
    tick();
    rsp_rdy = '0;
    last_m = 2;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL late_accept0: got %b want 0001", req_rdy); end
    serve(2, 8'h11, 1'b0, ok, g, da, ad, dt, w, rv, rd, re);
    req_val = '0;
    checks++; if (!ok || g !== 3'd0 || rv !== 4'b0001) begin errors++; $display("FAIL late_second: got g=%0d rv=%b want g=0 rv=0001", g, rv); end
    last_m = 0;
  endtask

  task automatic test_timeout();
    bit ok; int n;
    req_wen[1] = 1'b0;
    req_val = 4'b0010;
    wait_issue(ok);
    req_val = '0;
    tick();
    n = 0;
    while (rsp_val === 4'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL timeout_latency: got %0d cycles want 16", n); end
    checks++; if ({rsp_val, rsp_data, rsp_err} !== {4'b0010, 8'hFF, 1'b1})
      begin errors++; $display("FAIL timeout_rsp: got %h want %h", {rsp_val, rsp_data, rsp_err}, {4'b0010, 8'hFF, 1'b1}); end
    rsp_rdy = 4'b0010;
    tick();
    rsp_rdy = '0;
    last_m = 1;
    m_val_i = 1'b1; m_data_i = 8'h77;
    tick();
    m_val_i = 1'b0;
    checks++; if ({stray, rsp_val} !== 5'b10000) begin errors++; $display("FAIL stray_pulse: got %b want 10000", {stray, rsp_val}); end
    tick();
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", stray); end
  endtask

  task automatic test_write_err();
    bit ok;
    req_daddr[3] = 7'h3B; req_addr[3] = 8'h40; req_data[3] = 8'hC3; req_wen[3] = 1'b1;
    req_val = 4'b1000;
    wait_issue(ok);
    req_val = '0;
    checks++; if (!ok || {m_daddr, m_addr, m_wdata, m_wen} !== {7'h3B, 8'h40, 8'hC3, 1'b1})
      begin errors++; $display("FAIL werr_fields: got %h want %h", {m_daddr, m_addr, m_wdata, m_wen}, {7'h3B, 8'h40, 8'hC3, 1'b1}); end
    repeat (3) tick();
    m_val_i = 1'b1; m_err_i = 1'b1; m_data_i = 8'h3C;
    tick();
    m_val_i = 1'b0; m_err_i = 1'b0;
    rsp_rdy = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({rsp_val, rsp_data, rsp_err, m_rdy_o} !== {4'b1000, 8'h3C, 1'b1, 1'b0})
        begin errors++; $display("FAIL werr_hold: cycle %0d got %h want %h", c, {rsp_val, rsp_data, rsp_err, m_rdy_o}, {4'b1000, 8'h3C, 1'b1, 1'b0}); end
      tick();
    end
    rsp_rdy = 4'b1000;
    tick();
    rsp_rdy = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL werr_done: busy got %b want 0", busy); end
    last_m = 3;
  endtask

  task automatic test_random();
    bit ok; logic [2:0] g; logic [6:0] da; logic [7:0] ad, dt, rd; logic w, re; logic [N-1:0] rv;
    logic [N-1:0] pending, add; int exp; logic [7:0] d; logic e;
    pending = 4'($urandom_range(1, 15));
    for (int i = 0; i < N; i++) rand_fields(i);
    for (int t = 0; t < 12; t++) begin
      req_val = pending;
      exp = rr_exp(pending, last_m);
      d = 8'($urandom); e = 1'($urandom);
      serve($urandom_range(0, 10), d, e, ok, g, da, ad, dt, w, rv, rd, re);
      checks++; if (!ok || g !== 3'(exp)) begin errors++; $display("FAIL rand_grant: txn %0d got %0d want %0d", t, g, exp); end
      checks++; if ({da, ad, dt, w, rv, rd, re} !== {req_daddr[exp], req_addr[exp], req_data[exp], req_wen[exp], 4'(1 << exp), d, e})
        begin errors++; $display("FAIL rand_txn: txn %0d got %h want %h", t, {da, ad, dt, w, rv, rd, re},
          {req_daddr[exp], req_addr[exp], req_data[exp], req_wen[exp], 4'(1 << exp), d, e}); end
      last_m = exp;
      pending[exp] = 1'b0;
      add = 4'($urandom);
      for (int i = 0; i < N; i++) if (add[i] && !pending[i]) begin rand_fields(i); pending[i] = 1'b1; end
      if (pending == '0) begin
        pending[0] = 1'b1;
        rand_fields(0);
      end
    end
    req_val = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok; logic [2:0] g; logic [6:0] da; logic [7:0] ad, dt, rd; logic w, re; logic [N-1:0] rv;
    req_val = 4'b0010;
    wait_issue(ok);
    req_val = '0;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    req_val = '1;
    #1;
    checks++; if ({m_val_o, m_rdy_o, busy, stray, grant, rsp_val, req_rdy, m_daddr} !== 22'b0)
      begin errors++; $display("FAIL async_reset_outputs: got %h want 0", {m_val_o, m_rdy_o, busy, stray, grant, rsp_val, req_rdy, m_daddr}); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = N - 1;
    serve(1, 8'h22, 1'b0, ok, g, da, ad, dt, w, rv, rd, re);
    checks++; if (!ok || g !== 3'd0 || rv !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: got %0d want 0", g); end
    last_m = 0;
    req_val = 4'b0100;
    wait_issue(ok);
    req_val = '0;
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if ({busy, m_val_o, rsp_val} !== 6'b0) begin errors++; $display("FAIL srst_clear: got %b want 000000", {busy, m_val_o, rsp_val}); end
    req_val = '1;
    serve(0, 8'h33, 1'b0, ok, g, da, ad, dt, w, rv, rd, re);
    req_val = '0;
    checks++; if (!ok || g !== 3'd0) begin errors++; $display("FAIL post_srst_grant: got %0d want 0", g); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_late_request();
    test_timeout();
    test_write_err();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
